// File: rtl/llc_snoop_responder.sv
// rtl/llc_snoop_responder.sv - LLC snoop responder: MESI lookup, result, L1 message, writeback, state update
module llc_snoop_responder #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 14,
    parameter int OFF_W  = 6,
    parameter int WAY_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              snp_valid,
    output logic                              snp_ready,
    input  logic [2:0]                        snp_op,
    input  logic [ADDR_W-1:0]                 snp_addr,
    output logic                              res_valid,
    output logic [1:0]                        res_code,
    output logic                              lk_req,
    output logic [IDX_W-1:0]                  lk_index,
    output logic [ADDR_W-IDX_W-OFF_W-1:0]     lk_tag,
    input  logic                              lk_hit,
    input  logic [WAY_W-1:0]                  lk_way,
    input  logic [1:0]                        lk_state,
    output logic                              upd_en,
    output logic [IDX_W-1:0]                  upd_index,
    output logic [WAY_W-1:0]                  upd_way,
    output logic [1:0]                        upd_state,
    output logic                              l1_valid,
    input  logic                              l1_ready,
    output logic [1:0]                        l1_msg,
    output logic [ADDR_W-1:0]                 l1_addr,
    output logic                              wb_valid,
    input  logic                              wb_ready,
    output logic [ADDR_W-1:0]                 wb_addr,
    output logic                              proto_err,
    output logic [CNT_W-1:0]                  cnt_hit,
    output logic [CNT_W-1:0]                  cnt_hitm,
    output logic [CNT_W-1:0]                  cnt_nohit
);

    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = ADDR_W - OFF_W;

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;

    localparam logic [1:0] RES_HIT   = 2'd0;
    localparam logic [1:0] RES_HITM  = 2'd1;
    localparam logic [1:0] RES_NOHIT = 2'd2;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    localparam logic [1:0] MSG_INV   = 2'd1;
    localparam logic [1:0] MSG_GET   = 2'd2;
    localparam logic [1:0] MSG_EVICT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DECIDE,
        S_RESP,
        S_L1MSG,
        S_WB,
        S_UPDATE
    } fsm_t;

    fsm_t              state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [1:0]        res_code_q, res_code_d;
    logic [1:0]        new_state_q, new_state_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              l1_pend_q, l1_pend_d;
    logic [1:0]        l1_msg_q, l1_msg_d;
    logic              wb_pend_q, wb_pend_d;
    logic              upd_pend_q, upd_pend_d;
    logic              proto_err_q, proto_err_d;
    logic [CNT_W-1:0]  cnt_hit_q, cnt_hit_d;
    logic [CNT_W-1:0]  cnt_hitm_q, cnt_hitm_d;
    logic [CNT_W-1:0]  cnt_nohit_q, cnt_nohit_d;
    logic [1:0]        cur_state;

    assign cur_state = lk_hit ? lk_state : ST_I;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            line_q      <= '0;
            res_code_q  <= RES_NOHIT;
            new_state_q <= ST_I;
            way_q       <= '0;
            l1_pend_q   <= 1'b0;
            l1_msg_q    <= 2'd0;
            wb_pend_q   <= 1'b0;
            upd_pend_q  <= 1'b0;
            proto_err_q <= 1'b0;
            cnt_hit_q   <= '0;
            cnt_hitm_q  <= '0;
            cnt_nohit_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            line_q      <= line_d;
            res_code_q  <= res_code_d;
            new_state_q <= new_state_d;
            way_q       <= way_d;
            l1_pend_q   <= l1_pend_d;
            l1_msg_q    <= l1_msg_d;
            wb_pend_q   <= wb_pend_d;
            upd_pend_q  <= upd_pend_d;
            proto_err_q <= proto_err_d;
            cnt_hit_q   <= cnt_hit_d;
            cnt_hitm_q  <= cnt_hitm_d;
            cnt_nohit_q <= cnt_nohit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        line_d      = line_q;
        res_code_d  = res_code_q;
        new_state_d = new_state_q;
        way_d       = way_q;
        l1_pend_d   = l1_pend_q;
        l1_msg_d    = l1_msg_q;
        wb_pend_d   = wb_pend_q;
        upd_pend_d  = upd_pend_q;
        proto_err_d = proto_err_q;
        cnt_hit_d   = cnt_hit_q;
        cnt_hitm_d  = cnt_hitm_q;
        cnt_nohit_d = cnt_nohit_q;

        case (state_q)
            S_IDLE: begin
                if (snp_valid) begin
                    op_d    = snp_op;
                    line_d  = snp_addr[ADDR_W-1:OFF_W];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                res_code_d  = RES_NOHIT;
                new_state_d = cur_state;
                way_d       = lk_way;
                l1_pend_d   = 1'b0;
                l1_msg_d    = 2'd0;
                wb_pend_d   = 1'b0;
                upd_pend_d  = 1'b0;
                case (op_q)
                    OP_READ: begin
                        case (cur_state)
                            ST_S: res_code_d = RES_HIT;
                            ST_E: begin
                                res_code_d  = RES_HIT;
                                new_state_d = ST_S;
                                upd_pend_d  = 1'b1;
                            end
                            ST_M: begin
                                res_code_d  = RES_HITM;
                                new_state_d = ST_S;
                                l1_pend_d   = 1'b1;
                                l1_msg_d    = MSG_GET;
                                wb_pend_d   = 1'b1;
                                upd_pend_d  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_WRITE: begin
                        if (cur_state != ST_I) proto_err_d = 1'b1;
                    end
                    OP_INV: begin
                        case (cur_state)
                            ST_S: begin
                                res_code_d  = RES_HIT;
                                new_state_d = ST_I;
                                l1_pend_d   = 1'b1;
                                l1_msg_d    = MSG_INV;
                                upd_pend_d  = 1'b1;
                            end
                            ST_E, ST_M: proto_err_d = 1'b1;
                            default: ;
                        endcase
                    end
                    OP_RWIM: begin
                        case (cur_state)
                            ST_S, ST_E: begin
                                res_code_d  = RES_HIT;
                                new_state_d = ST_I;
                                l1_pend_d   = 1'b1;
                                l1_msg_d    = MSG_INV;
                                upd_pend_d  = 1'b1;
                            end
                            ST_M: begin
                                res_code_d  = RES_HITM;
                                new_state_d = ST_I;
                                l1_pend_d   = 1'b1;
                                l1_msg_d    = MSG_EVICT;
                                wb_pend_d   = 1'b1;
                                upd_pend_d  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: proto_err_d = 1'b1;
                endcase
                state_d = S_RESP;
            end
            S_RESP: begin
                case (res_code_q)
                    RES_HIT:  if (cnt_hit_q != '1) cnt_hit_d = cnt_hit_q + CNT_ONE;
                    RES_HITM: if (cnt_hitm_q != '1) cnt_hitm_d = cnt_hitm_q + CNT_ONE;
                    default:  if (cnt_nohit_q != '1) cnt_nohit_d = cnt_nohit_q + CNT_ONE;
                endcase
                if (l1_pend_q)       state_d = S_L1MSG;
                else if (upd_pend_q) state_d = S_UPDATE;
                else                 state_d = S_IDLE;
            end
            S_L1MSG: begin
                if (l1_ready) state_d = wb_pend_q ? S_WB : S_UPDATE;
            end
            S_WB: begin
                if (wb_ready) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign snp_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_RESP);
    assign res_code  = res_code_q;
    assign lk_req    = (state_q == S_LOOKUP);
    assign lk_index  = line_q[IDX_W-1:0];
    assign lk_tag    = line_q[LINE_W-1 -: TAG_W];
    assign upd_en    = (state_q == S_UPDATE);
    assign upd_index = line_q[IDX_W-1:0];
    assign upd_way   = way_q;
    assign upd_state = new_state_q;
    assign l1_valid  = (state_q == S_L1MSG);
    assign l1_msg    = l1_msg_q;
    assign l1_addr   = {line_q, {OFF_W{1'b0}}};
    assign wb_valid  = (state_q == S_WB);
    assign wb_addr   = {line_q, {OFF_W{1'b0}}};
    assign proto_err = proto_err_q;
    assign cnt_hit   = cnt_hit_q;
    assign cnt_hitm  = cnt_hitm_q;
    assign cnt_nohit = cnt_nohit_q;

endmodule

// File: tb/tb_llc_snoop_responder.sv
// tb/tb_llc_snoop_responder.sv - scoreboard bench for llc_snoop_responder
module tb_llc_snoop_responder;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        snp_valid;
    logic        snp_ready;
    logic [2:0]  snp_op;
    logic [31:0] snp_addr;
    logic        res_valid;
    logic [1:0]  res_code;
    logic        lk_req;
    logic [13:0] lk_index;
    logic [11:0] lk_tag;
    logic        lk_hit;
    logic [3:0]  lk_way;
    logic [1:0]  lk_state;
    logic        upd_en;
    logic [13:0] upd_index;
    logic [3:0]  upd_way;
    logic [1:0]  upd_state;
    logic        l1_valid;
    logic        l1_ready;
    logic [1:0]  l1_msg;
    logic [31:0] l1_addr;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_addr;
    logic        proto_err;
    logic [CW-1:0] cnt_hit;
    logic [CW-1:0] cnt_hitm;
    logic [CW-1:0] cnt_nohit;

    llc_snoop_responder #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .res_valid(res_valid), .res_code(res_code),
        .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
        .lk_hit(lk_hit), .lk_way(lk_way), .lk_state(lk_state),
        .upd_en(upd_en), .upd_index(upd_index), .upd_way(upd_way), .upd_state(upd_state),
        .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_msg(l1_msg), .l1_addr(l1_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .proto_err(proto_err),
        .cnt_hit(cnt_hit), .cnt_hitm(cnt_hitm), .cnt_nohit(cnt_nohit)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  exp_res[$];
    logic [19:0] exp_upd[$];
    logic [33:0] exp_l1[$];
    logic [31:0] exp_wb[$];

    int          l1_hold = 0;
    int          l1_last_hold = 0;
    logic [33:0] l1_first;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT produced an output with nothing expected", name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (exp_res.size() == 0) unexpected("res_extra");
                else check("res_code", 32'(res_code), 32'(exp_res.pop_front()));
            end
            if (upd_en) begin
                if (exp_upd.size() == 0) unexpected("upd_extra");
                else check("upd_fields", 32'({upd_index, upd_way, upd_state}), 32'(exp_upd.pop_front()));
            end
            if (l1_valid) begin
                l1_hold++;
                if (l1_hold == 1) l1_first = {l1_msg, l1_addr};
                else check("l1_stable", {l1_msg[1:0] ^ l1_first[33:32], 30'd0} | (l1_addr ^ l1_first[31:0]), 32'd0);
                if (l1_ready) begin
                    if (exp_l1.size() == 0) unexpected("l1_extra");
                    else begin
                        logic [33:0] e;
                        e = exp_l1.pop_front();
                        check("l1_msg", 32'(l1_msg), 32'(e[33:32]));
                        check("l1_addr", l1_addr, e[31:0]);
                    end
                    l1_last_hold = l1_hold;
                    l1_hold = 0;
                end
            end
            if (wb_valid && wb_ready) begin
                if (exp_wb.size() == 0) unexpected("wb_extra");
                else check("wb_addr", wb_addr, exp_wb.pop_front());
            end
        end
    end

    task automatic set_lk(input logic hit, input logic [3:0] way, input logic [1:0] st);
        lk_hit = hit;
        lk_way = way;
        lk_state = st;
    endtask

    task automatic snoop(input logic [2:0] op, input logic [31:0] addr);
        int n = 0;
        @(posedge clk); #1;
        while (!snp_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!snp_ready) unexpected("snoop_accept_timeout");
        snp_valid = 1'b1;
        snp_op    = op;
        snp_addr  = addr;
        @(posedge clk); #1;
        snp_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!snp_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!snp_ready) unexpected("idle_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        snp_valid = 1'b0;
        snp_op = 3'd0;
        snp_addr = 32'd0;
        l1_ready = 1'b1;
        wb_ready = 1'b1;
        set_lk(1'b0, 4'd0, 2'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_snp_ready", 32'(snp_ready), 32'd1);
        check("rst_res_code", 32'(res_code), 32'd2);
        check("rst_outputs", 32'({res_valid, lk_req, upd_en, l1_valid, wb_valid, proto_err}), 32'd0);
        check("rst_counters", 32'({cnt_hit, cnt_hitm, cnt_nohit}), 32'd0);

        // READ miss with latency checks
        exp_res.push_back(2'd2);
        snoop(3'd1, 32'h0000_1040);
        @(negedge clk);
        check("t1_lk_req_c1", 32'(lk_req), 32'd1);
        check("t1_lk_index", 32'(lk_index), 32'h41);
        repeat (2) @(negedge clk);
        check("t1_res_valid_c3", 32'(res_valid), 32'd1);
        @(negedge clk);
        check("t1_snp_ready_c4", 32'(snp_ready), 32'd1);
        check("t1_cnt_nohit", 32'(cnt_nohit), 32'd1);

        // READ E way 5, with an ignored offer while busy
        set_lk(1'b1, 4'd5, 2'd2);
        exp_res.push_back(2'd0);
        exp_upd.push_back({14'h0001, 4'd5, 2'd1});
        snoop(3'd1, 32'h0000_0040);
        snp_valid = 1'b1;
        snp_op = 3'd2;
        @(posedge clk); #1;
        snp_valid = 1'b0;
        wait_idle();
        check("t2_upd_drained", 32'(exp_upd.size()), 32'd0);

        // RWIM M with delayed l1_ready
        l1_ready = 1'b0;
        set_lk(1'b1, 4'd3, 2'd3);
        exp_res.push_back(2'd1);
        exp_l1.push_back({2'd3, 32'h1234_5640});
        exp_wb.push_back(32'h1234_5640);
        exp_upd.push_back({14'h1159, 4'd3, 2'd0});
        snoop(3'd4, 32'h1234_5678);
        begin
            int n = 0;
            @(negedge clk);
            while (!l1_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!l1_valid) unexpected("t3_l1_timeout");
        end
        repeat (3) @(posedge clk);
        #1 l1_ready = 1'b1;
        wait_idle();
        check("t3_l1_hold_cycles", 32'(l1_last_hold), 32'd4);
        check("t3_queues_drained", 32'(exp_l1.size() + exp_wb.size() + exp_upd.size()), 32'd0);

        // INVALIDATE on M, then illegal op
        set_lk(1'b1, 4'd2, 2'd3);
        exp_res.push_back(2'd2);
        snoop(3'd3, 32'h0000_3000);
        wait_idle();
        check("t4_proto_err_set", 32'(proto_err), 32'd1);
        set_lk(1'b0, 4'd0, 2'd0);
        exp_res.push_back(2'd2);
        snoop(3'd7, 32'h0000_4000);
        wait_idle();
        check("t4_proto_err_sticky", 32'(proto_err), 32'd1);
        check("t4_counters", 32'({cnt_hit, cnt_hitm, cnt_nohit}), 32'({4'd1, 4'd1, 4'd3}));

        // reset during writeback wait
        wb_ready = 1'b0;
        set_lk(1'b1, 4'd7, 2'd3);
        exp_res.push_back(2'd1);
        exp_l1.push_back({2'd2, 32'h0000_2000});
        snoop(3'd1, 32'h0000_2004);
        begin
            int n = 0;
            while (!wb_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!wb_valid) unexpected("t5_wb_timeout");
        end
        check("t5_wb_addr_pending", wb_addr, 32'h0000_2000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_wb_valid_cleared", 32'(wb_valid), 32'd0);
        check("t5_snp_ready", 32'(snp_ready), 32'd1);
        check("t5_counters_zero", 32'({cnt_hit, cnt_hitm, cnt_nohit, proto_err}), 32'd0);
        wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // counter saturation on the 4-bit build
        set_lk(1'b1, 4'd1, 2'd1);
        for (int i = 0; i < 14; i++) begin
            exp_res.push_back(2'd0);
            snoop(3'd1, 32'h0000_5000);
            wait_idle();
        end
        check("t6_cnt_hit_14", 32'(cnt_hit), 32'd14);
        for (int i = 0; i < 3; i++) begin
            exp_res.push_back(2'd0);
            snoop(3'd1, 32'h0000_5000);
            wait_idle();
            check("t6_cnt_hit_sat", 32'(cnt_hit), 32'd15);
        end

        repeat (3) @(posedge clk);
        check("final_res_drained", 32'(exp_res.size()), 32'd0);
        check("final_other_drained", 32'(exp_upd.size() + exp_l1.size() + exp_wb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
